// File: rtl/e203_ifu_bpu_jalr_sched.sv
// ---------------------------------------------------------------------------
// e203_ifu_bpu_jalr_sched
// Sequencing controller in front of the IFU lite branch predictor. It accepts
// decoded JAL/JALR/Bxx requests and decides when each prediction resolves.
// A JALR through x1 waits for operand hazards to clear. A JALR through any
// other register (xn) also claims the shared regfile rs1 read port and
// captures the read data. While a JALR operand is not yet available, the
// controller stalls the IFU with bpu_wait.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   pc, dec_*               decoded instruction and its branch/jump fields
//   oitf_empty, ir_*        hazard inputs from the EXU
//   jalr_rs1idx_cam_irrdidx JALR rs1 matches the rd of the IR instruction
//   rf2bpu_x1, rf2bpu_rs1   dedicated x1 value and shared rs1 port data
//   flush                   IFU flush; overrides everything
//   bpu_wait                IFU stall (the IFU holds dec_* stable)
//   bpu2rf_rs1_ena/_idx     shared rs1 port claim and read index
//   prdt_vld/taken/pc       registered prediction; prdt_vld is a 1-cycle pulse
//   wait_cnt                saturating count of hazard-wait cycles
//
// State table:
//   state | meaning
//   IDLE  | ready to accept; resolves JAL, Bxx, JALR-x0 and hazard-free JALR-x1
//   X1W   | JALR through x1 waiting for the dependency to clear
//   XNW   | JALR through xn waiting for the dependency or busy read port
//   RD    | shared rs1 read port claimed this cycle
//   CAP   | rs1 read data captured; the prediction resolves
// ---------------------------------------------------------------------------
module e203_ifu_bpu_jalr_sched #(
  parameter int PC_SIZE = 32,
  parameter int WCNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_SIZE-1:0] pc,
  input  logic               dec_i_valid,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic [PC_SIZE-1:0] dec_bjp_imm,
  input  logic [4:0]         dec_jalr_rs1idx,
  input  logic               oitf_empty,
  input  logic               ir_empty,
  input  logic               ir_rs1en,
  input  logic               jalr_rs1idx_cam_irrdidx,
  input  logic               ir_valid_clr,
  input  logic [PC_SIZE-1:0] rf2bpu_x1,
  input  logic [PC_SIZE-1:0] rf2bpu_rs1,
  input  logic               flush,
  output logic               bpu_wait,
  output logic               bpu2rf_rs1_ena,
  output logic [4:0]         bpu2rf_rs1_idx,
  output logic               prdt_vld,
  output logic               prdt_taken,
  output logic [PC_SIZE-1:0] prdt_pc,
  output logic [WCNT_W-1:0]  wait_cnt
);

  typedef enum logic [2:0] {IDLE, X1W, XNW, RD, CAP} state_t;

  state_t state, state_nxt;

  logic dep, busy;
  logic accept, acc_jalr, acc_jal, acc_bxx;
  logic rs1_is0, rs1_is1;
  logic [PC_SIZE-1:0] pc_sum;
  logic [PC_SIZE-1:0] imm_q;
  logic [4:0]         rs1idx_q;
  logic               resolve, res_taken;
  logic [PC_SIZE-1:0] res_pc;

  assign dep  = !oitf_empty | (!ir_empty & jalr_rs1idx_cam_irrdidx);
  assign busy = !ir_empty & ir_rs1en & !ir_valid_clr;

  // Accept priority on multiple flags: jalr > jal > bxx
  assign accept   = (state == IDLE) & !flush & dec_i_valid & (dec_jal | dec_jalr | dec_bxx);
  assign acc_jalr = accept & dec_jalr;
  assign acc_jal  = accept & !dec_jalr & dec_jal;
  assign acc_bxx  = accept & !dec_jalr & !dec_jal;

  assign rs1_is0 = (dec_jalr_rs1idx == 5'd0);
  assign rs1_is1 = (dec_jalr_rs1idx == 5'd1);
  assign pc_sum  = pc + dec_bjp_imm;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc_jalr && !rs1_is0) begin
          if (rs1_is1) begin
            if (dep) state_nxt = X1W;
          end else begin
            state_nxt = (!dep && !busy) ? RD : XNW;
          end
        end
      end
      X1W:     if (!dep) state_nxt = IDLE;
      XNW:     if (!dep && !busy) state_nxt = RD;
      RD:      state_nxt = CAP;
      CAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Output and resolve logic
  always_comb begin
    bpu_wait       = 1'b0;
    bpu2rf_rs1_ena = 1'b0;
    resolve        = 1'b0;
    res_taken      = 1'b0;
    res_pc         = '0;
    case (state)
      IDLE: begin
        if (acc_jal) begin
          resolve   = 1'b1;
          res_taken = 1'b1;
          res_pc    = pc_sum;
        end else if (acc_bxx) begin
          resolve   = 1'b1;
          res_taken = dec_bjp_imm[PC_SIZE-1];
          res_pc    = pc_sum;
        end else if (acc_jalr) begin
          if (rs1_is0) begin
            resolve   = 1'b1;
            res_taken = 1'b1;
            res_pc    = dec_bjp_imm;
          end else if (rs1_is1 && !dep) begin
            resolve   = 1'b1;
            res_taken = 1'b1;
            res_pc    = rf2bpu_x1 + dec_bjp_imm;
          end else begin
            bpu_wait = 1'b1;
          end
        end
      end
      X1W: begin
        bpu_wait = 1'b1;
        if (!dep) begin
          resolve   = 1'b1;
          res_taken = 1'b1;
          res_pc    = rf2bpu_x1 + imm_q;
        end
      end
      XNW: bpu_wait = 1'b1;
      RD: begin
        bpu_wait       = 1'b1;
        bpu2rf_rs1_ena = 1'b1;
      end
      CAP: begin
        bpu_wait  = 1'b1;
        resolve   = 1'b1;
        res_taken = 1'b1;
        res_pc    = rf2bpu_rs1 + imm_q;
      end
      default: ;
    endcase
  end

  // Datapath registers: prediction, latched JALR fields, port index, statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prdt_vld       <= 1'b0;
      prdt_taken     <= 1'b0;
      prdt_pc        <= '0;
      imm_q          <= '0;
      rs1idx_q       <= '0;
      bpu2rf_rs1_idx <= '0;
      wait_cnt       <= '0;
    end else begin
      prdt_vld <= resolve & !flush;
      if (resolve && !flush) begin
        prdt_taken <= res_taken;
        prdt_pc    <= res_pc;
      end
      if (acc_jalr) begin
        imm_q    <= dec_bjp_imm;
        rs1idx_q <= dec_jalr_rs1idx;
      end
      // The index is loaded on entry to RD; from IDLE it has not been latched yet.
      if (state_nxt == RD && state != RD)
        bpu2rf_rs1_idx <= (state == IDLE) ? dec_jalr_rs1idx : rs1idx_q;
      if ((state == X1W || state == XNW) && wait_cnt != '1)
        wait_cnt <= wait_cnt + WCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_e203_ifu_bpu_jalr_sched.sv
module tb_e203_ifu_bpu_jalr_sched;
  localparam int PC_SIZE = 32;
  localparam int WCNT_W  = 8;

  logic               clk;
  logic               rst_n;
  logic [PC_SIZE-1:0] pc;
  logic               dec_i_valid, dec_jal, dec_jalr, dec_bxx;
  logic [PC_SIZE-1:0] dec_bjp_imm;
  logic [4:0]         dec_jalr_rs1idx;
  logic               oitf_empty, ir_empty, ir_rs1en, jalr_rs1idx_cam_irrdidx, ir_valid_clr;
  logic [PC_SIZE-1:0] rf2bpu_x1, rf2bpu_rs1;
  logic               flush;
  logic               bpu_wait, bpu2rf_rs1_ena;
  logic [4:0]         bpu2rf_rs1_idx;
  logic               prdt_vld, prdt_taken;
  logic [PC_SIZE-1:0] prdt_pc;
  logic [WCNT_W-1:0]  wait_cnt;

  int n_pass  = 0;
  int n_total = 0;

  e203_ifu_bpu_jalr_sched #(.PC_SIZE(PC_SIZE), .WCNT_W(WCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .dec_i_valid(dec_i_valid),
    .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx),
    .dec_bjp_imm(dec_bjp_imm), .dec_jalr_rs1idx(dec_jalr_rs1idx),
    .oitf_empty(oitf_empty), .ir_empty(ir_empty), .ir_rs1en(ir_rs1en),
    .jalr_rs1idx_cam_irrdidx(jalr_rs1idx_cam_irrdidx), .ir_valid_clr(ir_valid_clr),
    .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1), .flush(flush),
    .bpu_wait(bpu_wait), .bpu2rf_rs1_ena(bpu2rf_rs1_ena), .bpu2rf_rs1_idx(bpu2rf_rs1_idx),
    .prdt_vld(prdt_vld), .prdt_taken(prdt_taken), .prdt_pc(prdt_pc), .wait_cnt(wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dec_i_valid = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
    pc = '0; dec_bjp_imm = '0; dec_jalr_rs1idx = '0;
    oitf_empty = 1; ir_empty = 1; ir_rs1en = 0; jalr_rs1idx_cam_irrdidx = 0;
    ir_valid_clr = 0; flush = 0;
  endtask

  task automatic issue(input logic jal, input logic jalr, input logic bxx,
                       input logic [31:0] p, input logic [31:0] imm, input logic [4:0] idx);
    dec_i_valid = 1; dec_jal = jal; dec_jalr = jalr; dec_bxx = bxx;
    pc = p; dec_bjp_imm = imm; dec_jalr_rs1idx = idx;
  endtask

  task automatic test_reset();
    idle_inputs();
    rf2bpu_x1 = '0; rf2bpu_rs1 = '0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    #1;
    n_total++; if (bpu_wait !== 1'b0) $display("FAIL reset_wait got=%0b exp=0", bpu_wait); else n_pass++;
    n_total++; if (bpu2rf_rs1_ena !== 1'b0) $display("FAIL reset_ena got=%0b exp=0", bpu2rf_rs1_ena); else n_pass++;
    n_total++; if (bpu2rf_rs1_idx !== 5'd0) $display("FAIL reset_idx got=%0d exp=0", bpu2rf_rs1_idx); else n_pass++;
    n_total++; if (prdt_vld !== 1'b0) $display("FAIL reset_vld got=%0b exp=0", prdt_vld); else n_pass++;
    n_total++; if (prdt_taken !== 1'b0) $display("FAIL reset_taken got=%0b exp=0", prdt_taken); else n_pass++;
    n_total++; if (prdt_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", prdt_pc); else n_pass++;
    n_total++; if (wait_cnt !== 8'd0) $display("FAIL reset_wcnt got=%0d exp=0", wait_cnt); else n_pass++;
  endtask

  task automatic test_jal();
    step();
    issue(1, 0, 0, 32'h1000, 32'h20, 5'd0);
    #1;
    n_total++; if (bpu_wait !== 1'b0) $display("FAIL jal_wait got=%0b exp=0", bpu_wait); else n_pass++;
    step();
    idle_inputs();
    #1;
    n_total++; if (prdt_vld !== 1'b1) $display("FAIL jal_vld got=%0b exp=1", prdt_vld); else n_pass++;
    n_total++; if (prdt_taken !== 1'b1) $display("FAIL jal_taken got=%0b exp=1", prdt_taken); else n_pass++;
    n_total++; if (prdt_pc !== 32'h1020) $display("FAIL jal_pc got=%h exp=00001020", prdt_pc); else n_pass++;
    step();
    n_total++; if (prdt_vld !== 1'b0) $display("FAIL jal_pulse got=%0b exp=0", prdt_vld); else n_pass++;
    n_total++; if (prdt_pc !== 32'h1020) $display("FAIL jal_hold got=%h exp=00001020", prdt_pc); else n_pass++;
  endtask

  task automatic test_bxx();
    issue(0, 0, 1, 32'h2000, 32'hFFFF_FFF0, 5'd0);
    step();
    issue(0, 0, 1, 32'h2000, 32'h10, 5'd0);
    #1;
    n_total++; if (prdt_taken !== 1'b1) $display("FAIL bxx_back_taken got=%0b exp=1", prdt_taken); else n_pass++;
    n_total++; if (prdt_pc !== 32'h1FF0) $display("FAIL bxx_back_pc got=%h exp=00001ff0", prdt_pc); else n_pass++;
    step();
    idle_inputs();
    #1;
    n_total++; if (prdt_vld !== 1'b1) $display("FAIL bxx_fwd_vld got=%0b exp=1", prdt_vld); else n_pass++;
    n_total++; if (prdt_taken !== 1'b0) $display("FAIL bxx_fwd_taken got=%0b exp=0", prdt_taken); else n_pass++;
    n_total++; if (prdt_pc !== 32'h2010) $display("FAIL bxx_fwd_pc got=%h exp=00002010", prdt_pc); else n_pass++;
    step();
  endtask

  task automatic test_jalr_x0();
    // jal also set: jalr must win priority and ignore pc
    issue(1, 1, 0, 32'h9000, 32'h4000, 5'd0);
    #1;
    n_total++; if (bpu_wait !== 1'b0) $display("FAIL jalr0_wait got=%0b exp=0", bpu_wait); else n_pass++;
    step();
    idle_inputs();
    #1;
    n_total++; if (prdt_vld !== 1'b1) $display("FAIL jalr0_vld got=%0b exp=1", prdt_vld); else n_pass++;
    n_total++; if (prdt_pc !== 32'h4000) $display("FAIL jalr0_pc got=%h exp=00004000", prdt_pc); else n_pass++;
    step();
  endtask

  task automatic test_jalr_x1();
    int waits = 0;
    rf2bpu_x1 = 32'h8000;
    issue(0, 1, 0, 32'h0, 32'h4, 5'd1);
    for (int i = 0; i < 4; i++) begin
      oitf_empty = (i >= 3);
      #1;
      if (bpu_wait) waits++;
      n_total++; if (prdt_vld !== 1'b0) $display("FAIL x1_early_vld cyc=%0d got=%0b exp=0", i, prdt_vld); else n_pass++;
      step();
    end
    idle_inputs();
    #1;
    n_total++; if (waits != 4) $display("FAIL x1_wait_cycles got=%0d exp=4", waits); else n_pass++;
    n_total++; if (bpu_wait !== 1'b0) $display("FAIL x1_wait_off got=%0b exp=0", bpu_wait); else n_pass++;
    n_total++; if (prdt_vld !== 1'b1) $display("FAIL x1_vld got=%0b exp=1", prdt_vld); else n_pass++;
    n_total++; if (prdt_pc !== 32'h8004) $display("FAIL x1_pc got=%h exp=00008004", prdt_pc); else n_pass++;
    n_total++; if (wait_cnt !== 8'd3) $display("FAIL x1_wcnt got=%0d exp=3", wait_cnt); else n_pass++;
    step();
  endtask

  task automatic test_jalr_xn();
    issue(0, 1, 0, 32'h0, 32'h8, 5'd5);
    #1;
    n_total++; if (bpu_wait !== 1'b1) $display("FAIL xn_k_wait got=%0b exp=1", bpu_wait); else n_pass++;
    n_total++; if (bpu2rf_rs1_ena !== 1'b0) $display("FAIL xn_k_ena got=%0b exp=0", bpu2rf_rs1_ena); else n_pass++;
    step();
    n_total++; if (bpu2rf_rs1_ena !== 1'b1) $display("FAIL xn_k1_ena got=%0b exp=1", bpu2rf_rs1_ena); else n_pass++;
    n_total++; if (bpu2rf_rs1_idx !== 5'd5) $display("FAIL xn_k1_idx got=%0d exp=5", bpu2rf_rs1_idx); else n_pass++;
    step();
    rf2bpu_rs1 = 32'h3000;
    #1;
    n_total++; if (bpu2rf_rs1_ena !== 1'b0) $display("FAIL xn_k2_ena got=%0b exp=0", bpu2rf_rs1_ena); else n_pass++;
    n_total++; if (prdt_vld !== 1'b0) $display("FAIL xn_k2_vld got=%0b exp=0", prdt_vld); else n_pass++;
    step();
    idle_inputs();
    rf2bpu_rs1 = 32'hDEAD_0000;
    #1;
    n_total++; if (prdt_vld !== 1'b1) $display("FAIL xn_k3_vld got=%0b exp=1", prdt_vld); else n_pass++;
    n_total++; if (prdt_pc !== 32'h3008) $display("FAIL xn_k3_pc got=%h exp=00003008", prdt_pc); else n_pass++;
    n_total++; if (bpu_wait !== 1'b0) $display("FAIL xn_k3_wait got=%0b exp=0", bpu_wait); else n_pass++;
    step();
  endtask

  task automatic test_xn_busy();
    issue(0, 1, 0, 32'h0, 32'h10, 5'd5);
    ir_empty = 0; ir_rs1en = 1;
    for (int i = 0; i < 4; i++) begin
      ir_valid_clr = (i == 2);
      if (i == 3) begin ir_empty = 1; ir_rs1en = 0; ir_valid_clr = 0; end
      #1;
      n_total++;
      if (bpu2rf_rs1_ena !== (i == 3)) $display("FAIL busy_ena cyc=%0d got=%0b exp=%0b", i, bpu2rf_rs1_ena, (i == 3));
      else n_pass++;
      step();
    end
    rf2bpu_rs1 = 32'h5000;
    #1;
    n_total++; if (wait_cnt !== 8'd5) $display("FAIL busy_wcnt got=%0d exp=5", wait_cnt); else n_pass++;
    step();
    idle_inputs();
    #1;
    n_total++; if (prdt_vld !== 1'b1) $display("FAIL busy_vld got=%0b exp=1", prdt_vld); else n_pass++;
    n_total++; if (prdt_pc !== 32'h5010) $display("FAIL busy_pc got=%h exp=00005010", prdt_pc); else n_pass++;
    step();
  endtask

  task automatic test_flush_rd();
    issue(0, 1, 0, 32'h0, 32'h8, 5'd7);
    step();
    flush = 1;
    #1;
    n_total++; if (bpu2rf_rs1_idx !== 5'd7) $display("FAIL flush_idx got=%0d exp=7", bpu2rf_rs1_idx); else n_pass++;
    step();
    idle_inputs();
    #1;
    n_total++; if (bpu2rf_rs1_ena !== 1'b0) $display("FAIL flush_ena got=%0b exp=0", bpu2rf_rs1_ena); else n_pass++;
    n_total++; if (bpu_wait !== 1'b0) $display("FAIL flush_wait got=%0b exp=0", bpu_wait); else n_pass++;
    n_total++; if (prdt_vld !== 1'b0) $display("FAIL flush_vld1 got=%0b exp=0", prdt_vld); else n_pass++;
    step();
    n_total++; if (prdt_vld !== 1'b0) $display("FAIL flush_vld2 got=%0b exp=0", prdt_vld); else n_pass++;
    n_total++; if (prdt_pc !== 32'h5010) $display("FAIL flush_pc_hold got=%h exp=00005010", prdt_pc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue(1, 0, 0, 32'hFFFF_FFF0, 32'h20, 5'd0);
    step();
    issue(0, 0, 1, 32'h200, 32'hFFFF_FFFC, 5'd0);
    #1;
    n_total++; if (prdt_vld !== 1'b1) $display("FAIL b2b_vld1 got=%0b exp=1", prdt_vld); else n_pass++;
    n_total++; if (prdt_pc !== 32'h10) $display("FAIL b2b_wrap_pc got=%h exp=00000010", prdt_pc); else n_pass++;
    step();
    idle_inputs();
    #1;
    n_total++; if (prdt_vld !== 1'b1) $display("FAIL b2b_vld2 got=%0b exp=1", prdt_vld); else n_pass++;
    n_total++; if (prdt_pc !== 32'h1FC) $display("FAIL b2b_pc2 got=%h exp=000001fc", prdt_pc); else n_pass++;
    n_total++; if (prdt_taken !== 1'b1) $display("FAIL b2b_taken got=%0b exp=1", prdt_taken); else n_pass++;
    step();
  endtask

  task automatic test_wait_sat();
    rf2bpu_x1 = 32'h40;
    issue(0, 1, 0, 32'h0, 32'h0, 5'd1);
    oitf_empty = 0;
    for (int i = 0; i < 300; i++) step();
    oitf_empty = 1;
    step();
    idle_inputs();
    #1;
    n_total++; if (wait_cnt !== 8'hFF) $display("FAIL sat_wcnt got=%0d exp=255", wait_cnt); else n_pass++;
    n_total++; if (prdt_vld !== 1'b1) $display("FAIL sat_vld got=%0b exp=1", prdt_vld); else n_pass++;
    n_total++; if (prdt_pc !== 32'h40) $display("FAIL sat_pc got=%h exp=00000040", prdt_pc); else n_pass++;
    step();
  endtask

  task automatic test_reset_xnw();
    issue(0, 1, 0, 32'h0, 32'h8, 5'd9);
    ir_empty = 0; ir_rs1en = 1;
    step(); step();
    rst_n = 0;
    idle_inputs();
    step();
    rst_n = 1;
    #1;
    n_total++; if (bpu_wait !== 1'b0) $display("FAIL rstx_wait got=%0b exp=0", bpu_wait); else n_pass++;
    n_total++; if (bpu2rf_rs1_ena !== 1'b0) $display("FAIL rstx_ena got=%0b exp=0", bpu2rf_rs1_ena); else n_pass++;
    n_total++; if (bpu2rf_rs1_idx !== 5'd0) $display("FAIL rstx_idx got=%0d exp=0", bpu2rf_rs1_idx); else n_pass++;
    n_total++; if (prdt_vld !== 1'b0) $display("FAIL rstx_vld got=%0b exp=0", prdt_vld); else n_pass++;
    n_total++; if (prdt_taken !== 1'b0) $display("FAIL rstx_taken got=%0b exp=0", prdt_taken); else n_pass++;
    n_total++; if (prdt_pc !== 32'h0) $display("FAIL rstx_pc got=%h exp=0", prdt_pc); else n_pass++;
    n_total++; if (wait_cnt !== 8'd0) $display("FAIL rstx_wcnt got=%0d exp=0", wait_cnt); else n_pass++;
    step();
    n_total++; if (prdt_vld !== 1'b0) $display("FAIL rstx_vld_after got=%0b exp=0", prdt_vld); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_jal();
    test_bxx();
    test_jalr_x0();
    test_jalr_x1();
    test_jalr_xn();
    test_xn_busy();
    test_flush_rd();
    test_back_to_back();
    test_wait_sat();
    test_reset_xnw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
